// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer and the instruction decoder.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_INVALID = 2'b01;
    localparam logic [1:0] ERR_IMEM_TO = 2'b10;
    localparam logic [1:0] ERR_DMEM_TO = 2'b11;

    localparam logic [5:0] OP_R  = 6'b000000;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_J  = 6'b000010;

    function automatic logic [31:0] jump_target(input logic [31:0] cur_pc, input logic [31:0] inst);
        return {cur_pc[31:28], inst[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/ack_watchdog.sv
// Counts consecutive cycles a request waits for its ack; flags the last allowed cycle.
module ack_watchdog #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clear,
    input  logic         run,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (run)
            cnt <= cnt + W'(1);
    end

    // Fires during the limit-th waiting cycle so the FSM leaves on that edge.
    assign expired = run && (cnt == limit - W'(1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: owns pc/ir/retired and walks FETCH..WB with imem/dmem handshakes.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 255,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             resetn,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir,
    input  logic             dec_wen,
    input  logic             dec_alu_en,
    input  logic             dec_mem_rd,
    input  logic             dec_mem_wr,
    input  logic             dec_jmp,
    input  logic             dec_invalid,
    output logic             rf_rd_en,
    output logic             alu_go,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             rf_we,
    output logic [31:0]      pc,
    output logic             halted,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] retired
);

    localparam logic [15:0] LIMIT = 16'(ACK_TIMEOUT);

    state_t state;
    logic   live;
    logic   wait_run;
    logic   expired;
    logic   unused;

    // ALU op selection lives in the datapath; sequencing only needs mem/jmp/wen.
    assign unused = dec_alu_en;

    // live keeps imem_req low until the first edge after reset release.
    assign imem_req  = live && (state == S_FETCH);
    assign imem_addr = pc;
    assign rf_rd_en  = (state == S_DECODE);
    assign alu_go    = (state == S_EXEC);
    assign dmem_req  = (state == S_MEM);
    assign dmem_we   = dmem_req && dec_mem_wr;
    assign rf_we     = (state == S_WB) && dec_wen;
    assign halted    = (state == S_HALT);

    assign wait_run = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);

    ack_watchdog #(.W(16)) u_wdog (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (!wait_run),
        .run     (wait_run),
        .limit   (LIMIT),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_FETCH;
            live     <= 1'b0;
            pc       <= RESET_PC;
            ir       <= '0;
            retired  <= '0;
            err_code <= ERR_NONE;
        end else begin
            live <= 1'b1;
            unique case (state)
                S_FETCH: begin
                    if (imem_req && imem_ack) begin
                        ir    <= imem_rdata;
                        state <= S_DECODE;
                    end else if (expired) begin
                        err_code <= ERR_IMEM_TO;
                        state    <= S_HALT;
                    end
                end
                S_DECODE: begin
                    if (dec_invalid) begin
                        err_code <= ERR_INVALID;
                        state    <= S_HALT;
                    end else if (dec_jmp) begin
                        pc      <= jump_target(pc, ir);
                        retired <= retired + CNT_W'(1);
                        state   <= S_FETCH;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: state <= (dec_mem_rd || dec_mem_wr) ? S_MEM : S_WB;
                S_MEM: begin
                    if (dmem_ack) begin
                        if (dec_mem_wr) begin
                            pc      <= pc + 32'd4;
                            retired <= retired + CNT_W'(1);
                            state   <= S_FETCH;
                        end else begin
                            state <= S_WB;
                        end
                    end else if (expired) begin
                        err_code <= ERR_DMEM_TO;
                        state    <= S_HALT;
                    end
                end
                S_WB: begin
                    pc      <= pc + 32'd4;
                    retired <= retired + CNT_W'(1);
                    state   <= S_FETCH;
                end
                S_HALT: ;
                default: state <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: per-instruction behaviour compared against a cycle-budget reference model.
module tb_multicycle_ctrl;
    import cpu_ctrl_pkg::*;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int          ACK_TO = 4;

    typedef struct packed {
        int          cyc;
        int          n_rd;
        int          p_rd;
        int          n_alu;
        int          p_alu;
        int          n_we;
        int          p_we;
        int          n_dreq;
        logic        wr;
        logic        both;
        logic        addr_bad;
        logic [31:0] pc;
        logic [31:0] ret;
        logic [1:0]  err;
        logic        hlt;
    } obs_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0, ir;
    logic        dec_wen, dec_alu_en, dec_mem_rd, dec_mem_wr, dec_jmp, dec_invalid;
    logic        rf_rd_en, alu_go, dmem_req, dmem_we, dmem_ack = 1'b0, rf_we;
    logic [31:0] pc;
    logic        halted;
    logic [1:0]  err_code;
    logic [31:0] retired;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] m_pc;
    logic [31:0] m_ret;

    always #5 clk = ~clk;

    multicycle_ctrl #(.RESET_PC(RST_PC), .ACK_TIMEOUT(ACK_TO), .CNT_W(32)) dut (
        .clk(clk), .resetn(resetn), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir), .dec_wen(dec_wen),
        .dec_alu_en(dec_alu_en), .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr),
        .dec_jmp(dec_jmp), .dec_invalid(dec_invalid), .rf_rd_en(rf_rd_en), .alu_go(alu_go),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .rf_we(rf_we),
        .pc(pc), .halted(halted), .err_code(err_code), .retired(retired)
    );

    // Instruction decoder stand-in
    always_comb begin
        dec_wen = 1'b0; dec_alu_en = 1'b0; dec_mem_rd = 1'b0;
        dec_mem_wr = 1'b0; dec_jmp = 1'b0; dec_invalid = 1'b0;
        case (ir[31:26])
            OP_R:    begin dec_alu_en = 1'b1; dec_wen = 1'b1; end
            OP_LW:   begin dec_mem_rd = 1'b1; dec_wen = 1'b1; end
            OP_SW:   dec_mem_wr = 1'b1;
            OP_J:    dec_jmp = 1'b1;
            default: dec_invalid = 1'b1;
        endcase
    end

    function automatic string fmt(input obs_t o);
        return $sformatf("cyc=%0d rd=%0d@%0d alu=%0d@%0d we=%0d@%0d dreq=%0d wr=%0b both=%0b addr_bad=%0b pc=%h ret=%0d err=%0d hlt=%0b",
            o.cyc, o.n_rd, o.p_rd, o.n_alu, o.p_alu, o.n_we, o.p_we, o.n_dreq, o.wr, o.both,
            o.addr_bad, o.pc, o.ret, o.err, o.hlt);
    endfunction

    // Reference model: phase budget per instruction class, timeouts after ACK_TO waiting cycles.
    function automatic obs_t model(input logic [31:0] inst, input int idly, input int ddly,
                                   input logic [31:0] cpc, input logic [31:0] cret);
        obs_t       e;
        logic [5:0] op;
        logic       mem;
        op  = inst[31:26];
        mem = (op == OP_LW) || (op == OP_SW);
        e = '0;
        e.pc  = cpc;
        e.ret = cret;
        if (idly >= ACK_TO) begin
            e.cyc = ACK_TO; e.err = 2'b10; e.hlt = 1'b1;
            return e;
        end
        e.n_rd = 1; e.p_rd = idly + 2;
        if (!(op == OP_R || mem || op == OP_J)) begin
            e.cyc = idly + 2; e.err = 2'b01; e.hlt = 1'b1;
            return e;
        end
        if (op == OP_J) begin
            e.cyc = idly + 2;
            e.pc  = {cpc[31:28], inst[25:0], 2'b00};
            e.ret = cret + 1;
            return e;
        end
        e.n_alu = 1; e.p_alu = idly + 3;
        if (mem) begin
            e.wr = (op == OP_SW);
            if (ddly >= ACK_TO) begin
                e.n_dreq = ACK_TO; e.cyc = idly + 3 + ACK_TO; e.err = 2'b11; e.hlt = 1'b1;
                return e;
            end
            e.n_dreq = ddly + 1;
        end
        if (op == OP_R)       e.cyc = idly + 4;
        else if (op == OP_LW) e.cyc = idly + 5 + ddly;
        else                  e.cyc = idly + 4 + ddly;
        if (op != OP_SW) begin
            e.n_we = 1; e.p_we = e.cyc;
        end
        e.pc  = cpc + 32'd4;
        e.ret = cret + 1;
        return e;
    endfunction

    // Drives memory acks for one instruction; stops on retire, halt or a 60-cycle budget.
    task automatic exec_one(input logic [31:0] inst, input int idly, input int ddly, output obs_t o);
        int          wi, wd;
        logic [31:0] r0;
        o = '0; wi = 0; wd = 0; r0 = retired;
        while (o.cyc < 60) begin
            imem_ack = 1'b0; dmem_ack = 1'b0;
            if (imem_req) begin
                if (imem_addr !== pc) o.addr_bad = 1'b1;
                if (wi == idly) begin imem_ack = 1'b1; imem_rdata = inst; end
                else begin wi++; imem_rdata = $urandom; end
            end
            if (dmem_req) begin
                o.n_dreq++;
                if (dmem_we) o.wr = 1'b1;
                if (wd == ddly) dmem_ack = 1'b1; else wd++;
            end
            if (imem_req && dmem_req) o.both = 1'b1;
            if (rf_rd_en) begin o.n_rd++;  if (o.p_rd == 0)  o.p_rd  = o.cyc + 1; end
            if (alu_go)   begin o.n_alu++; if (o.p_alu == 0) o.p_alu = o.cyc + 1; end
            if (rf_we)    begin o.n_we++;  if (o.p_we == 0)  o.p_we  = o.cyc + 1; end
            @(posedge clk);
            o.cyc++;
            @(negedge clk);
            imem_ack = 1'b0; dmem_ack = 1'b0;
            if (retired !== r0 || halted) break;
        end
        o.pc = pc; o.ret = retired; o.err = err_code; o.hlt = halted;
    endtask

    task automatic do_reset();
        resetn = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        m_pc = RST_PC; m_ret = '0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({imem_req, dmem_req, rf_rd_en, alu_go, rf_we, halted, err_code, pc, ir, retired} !==
            {6'b0, 2'b00, RST_PC, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_state: req=%b dreq=%b pc=%h ir=%h ret=%0d hlt=%b err=%0d, want all 0 pc=%h",
                     imem_req, dmem_req, pc, ir, retired, halted, err_code, RST_PC);
        end
        resetn = 1'b1;
        #1;
        n_tests++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL req_before_edge: imem_req=%b want 0", imem_req);
        end
        @(posedge clk); #1;
        n_tests++;
        if (imem_req !== 1'b1) begin
            n_fail++; $display("FAIL req_after_edge: imem_req=%b want 1", imem_req);
        end
        @(negedge clk);
        m_pc = RST_PC; m_ret = '0;
    endtask

    task automatic run_check(input string name, input logic [31:0] inst, input int idly, input int ddly);
        obs_t o, e;
        e = model(inst, idly, ddly, m_pc, m_ret);
        exec_one(inst, idly, ddly, o);
        n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL %s inst=%h: got %s | want %s", name, inst, fmt(o), fmt(e));
        end
        if (!e.hlt) begin m_pc = e.pc; m_ret = e.ret; end
    endtask

    task automatic test_add();
        run_check("add_zero_wait", 32'h0022_1820, 0, 0);
        n_tests++;
        if (ir !== 32'h0022_1820) begin
            n_fail++; $display("FAIL add_ir: ir=%h want 00221820", ir);
        end
    endtask

    task automatic test_lw();
        run_check("lw_dmem_wait3", 32'h8C25_0008, 1, 3);
    endtask

    task automatic test_sw_j();
        run_check("sw_no_rf_we", 32'hAC25_0004, 0, 2);
        run_check("j_target", 32'h0800_0040, 0, 0);
        n_tests++;
        if (pc !== 32'h0000_0100) begin
            n_fail++; $display("FAIL j_pc: pc=%h want 00000100", pc);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] inst;
        logic [5:0]  ops [4];
        ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_J;
        for (int i = 0; i < 30; i++) begin
            inst = $urandom;
            inst[31:26] = ops[$urandom_range(0, 3)];
            run_check("random_seq", inst, $urandom_range(0, ACK_TO - 1), $urandom_range(0, ACK_TO - 1));
        end
    endtask

    task automatic test_reset_mid_mem();
        imem_ack = 1'b1; imem_rdata = 32'h8C25_0008;
        @(posedge clk); @(negedge clk);
        imem_ack = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        n_tests++;
        if ({dmem_req, dmem_we} !== 2'b10) begin
            n_fail++; $display("FAIL mid_mem_entry: dmem_req=%b dmem_we=%b want 1 0", dmem_req, dmem_we);
        end
        #2 resetn = 1'b0;
        #1;
        n_tests++;
        if ({dmem_req, imem_req, halted, pc, retired} !== {3'b000, RST_PC, 32'h0}) begin
            n_fail++;
            $display("FAIL mid_mem_reset: dreq=%b ireq=%b hlt=%b pc=%h ret=%0d want 0 0 0 %h 0",
                     dmem_req, imem_req, halted, pc, retired, RST_PC);
        end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_invalid();
        logic [31:0] pc0, ret0, ir0;
        logic        act;
        do_reset();
        run_check("invalid_halt", 32'h3F00_0000, 0, 0);
        pc0 = pc; ret0 = retired; ir0 = ir; act = 1'b0;
        repeat (8) begin
            imem_ack = 1'b1; dmem_ack = 1'b1; imem_rdata = $urandom;
            if (imem_req || dmem_req || rf_we || rf_rd_en || alu_go) act = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        imem_ack = 1'b0; dmem_ack = 1'b0;
        n_tests++;
        if ({act, halted, err_code, pc, retired, ir} !== {2'b01, 2'b01, pc0, ret0, 32'h3F00_0000} || ir0 !== 32'h3F00_0000) begin
            n_fail++;
            $display("FAIL halt_frozen: act=%b hlt=%b err=%0d pc=%h ret=%0d ir=%h want 0 1 1 %h %0d 3f000000",
                     act, halted, err_code, pc, retired, ir, pc0, ret0);
        end
    endtask

    task automatic test_timeouts();
        do_reset();
        run_check("imem_ack_last_cycle", 32'h0022_1820, ACK_TO - 1, 0);
        do_reset();
        run_check("imem_timeout", 32'h0022_1820, 99, 0);
        n_tests++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL imem_timeout_req_drop: imem_req=%b want 0", imem_req);
        end
        do_reset();
        run_check("dmem_ack_last_cycle", 32'hAC25_0004, 0, ACK_TO - 1);
        do_reset();
        run_check("dmem_timeout", 32'h8C25_0008, 2, 99);
        n_tests++;
        if (dmem_req !== 1'b0) begin
            n_fail++; $display("FAIL dmem_timeout_req_drop: dmem_req=%b want 0", dmem_req);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw();
        test_sw_j();
        test_back_to_back();
        test_reset_mid_mem();
        test_invalid();
        test_timeouts();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
